// File: rtl/pong_mmio_if.sv
// Processor data-memory bus as seen by the Pong MMIO controller.
// master = CPU/RAM side, slave = controller.
interface pong_mmio_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] address_dmem;
  logic [31:0]       data;
  logic              wren;
  logic [31:0]       dmem_q;
  logic [31:0]       q_dmem;
  logic              ram_wren;

  modport master (
    output address_dmem, data, wren, dmem_q,
    input  q_dmem, ram_wren
  );

  modport slave (
    input  address_dmem, data, wren, dmem_q,
    output q_dmem, ram_wren
  );
endinterface

// File: rtl/pong_mmio_ctrl.sv
// Pong MMIO controller: RAM write guard, vsync-committed VGA registers, PS2 key FIFO.
// Optional KEY_FILTER_EN: push only W/S/O/K/space make codes, drop F0 break pairs.
module pong_mmio_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int RAM_LIMIT  = 2000,
  parameter int MMIO_BASE  = 3000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       resetn,
  pong_mmio_if.slave bus,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  input  logic       vga_vs,
  output logic [9:0] vga_ball_x,
  output logic [8:0] vga_ball_y,
  output logic [8:0] vga_paddle_left,
  output logic [8:0] vga_paddle_right,
  output logic       key_irq
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = PW - 1;

  typedef enum logic {IDLE, PENDING} state_e;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] off_full;
  logic [2:0]        off;
  logic              in_win;
  logic              wr_win;
  logic [3:0]        sh_we;
  logic              unused_bits;

  assign addr     = bus.address_dmem;
  assign off_full = addr - ADDR_W'(MMIO_BASE);
  assign off      = off_full[2:0];
  assign in_win   = (addr >= ADDR_W'(MMIO_BASE)) &&
                    (addr < ADDR_W'(MMIO_BASE + 8));
  assign wr_win   = bus.wren & in_win;
  assign unused_bits = ^{bus.data[31:10], off_full[ADDR_W-1:3]};

  assign bus.ram_wren = bus.wren & (addr < ADDR_W'(RAM_LIMIT));

  always_comb begin
    sh_we = '0;
    for (int i = 0; i < 4; i++)
      sh_we[i] = wr_win && (off == 3'(i));
  end

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [9:0]  sh_x_q, sh_x_d, lv_x_q, lv_x_d;
  logic [8:0]  sh_y_q, sh_y_d, lv_y_q, lv_y_d;
  logic [8:0]  sh_l_q, sh_l_d, lv_l_q, lv_l_d;
  logic [8:0]  sh_r_q, sh_r_d, lv_r_q, lv_r_d;
  logic        vs1_q, vs2_q, vsp_q, vs_ev;
  logic [15:0] frame_q, frame_d;

  assign vs_ev = vsp_q & ~vs2_q;
  assign frame_d = frame_q + 16'(vs_ev);

  always_comb begin
    sh_x_d = sh_we[0] ? bus.data[9:0] : sh_x_q;
    sh_y_d = sh_we[1] ? bus.data[8:0] : sh_y_q;
    sh_l_d = sh_we[2] ? bus.data[8:0] : sh_l_q;
    sh_r_d = sh_we[3] ? bus.data[8:0] : sh_r_q;
    mode_d = (wr_win && off == 3'd6) ? bus.data[0] : mode_q;
  end

  // Commit copies the pre-write shadows; a racing write re-arms PENDING
  always_comb begin
    logic copy;
    copy    = 1'b0;
    state_d = state_q;
    unique case (state_q)
      IDLE: if (mode_q && |sh_we) state_d = PENDING;
      PENDING: begin
        if (!mode_q) begin
          copy    = 1'b1;
          state_d = IDLE;
        end else if (vs_ev) begin
          copy    = 1'b1;
          state_d = |sh_we ? PENDING : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    lv_x_d = copy ? sh_x_q : lv_x_q;
    lv_y_d = copy ? sh_y_q : lv_y_q;
    lv_l_d = copy ? sh_l_q : lv_l_q;
    lv_r_d = copy ? sh_r_q : lv_r_q;
    if (!mode_q) begin
      if (sh_we[0]) lv_x_d = sh_x_d;
      if (sh_we[1]) lv_y_d = sh_y_d;
      if (sh_we[2]) lv_l_d = sh_l_d;
      if (sh_we[3]) lv_r_d = sh_r_d;
    end
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic          kp_q, kp_rise, push_req;
  logic          empty, full, do_pop, do_push;
  logic          ovf_q, ovf_d;
  logic [7:0]    head;

  assign kp_rise = ps2_key_pressed & ~kp_q;
  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop  = wr_win && (off == 3'd4) && !empty;
  assign do_push = push_req && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem_q[rp_q[AW-1:0]];
  assign key_irq = !empty;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_win && off == 3'd5 && bus.data[2]) ovf_d = 1'b0;
    if (push_req && full && !do_pop) ovf_d = 1'b1;
  end

`ifdef KEY_FILTER_EN
  logic skip_q, skip_d;
  always_comb begin
    skip_d   = skip_q;
    push_req = 1'b0;
    if (kp_rise) begin
      if (skip_q) skip_d = 1'b0;
      else if (ps2_key_data == 8'hF0) skip_d = 1'b1;
      else push_req = ps2_key_data inside
        {8'h1D, 8'h1B, 8'h44, 8'h42, 8'h29};
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) skip_q <= 1'b0;
    else         skip_q <= skip_d;
  end
`else
  assign push_req = kp_rise;
`endif

  logic        sel_q;
  logic [31:0] rdata_q, rd_val;

  always_comb begin
    rd_val = '0;
    case (off)
      3'd0: rd_val = {22'b0, sh_x_q};
      3'd1: rd_val = {23'b0, sh_y_q};
      3'd2: rd_val = {23'b0, sh_l_q};
      3'd3: rd_val = {23'b0, sh_r_q};
      3'd4: rd_val = {23'b0, !empty, head};
      3'd5: rd_val = {frame_q, 13'b0, ovf_q, full, !empty};
      3'd6: rd_val = {31'b0, mode_q};
      default: rd_val = '0;
    endcase
    if (!in_win) rd_val = '0;
  end

  assign bus.q_dmem = sel_q ? rdata_q : bus.dmem_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      mode_q  <= 1'b1;
      sh_x_q  <= 10'd320;
      sh_y_q  <= 9'd240;
      sh_l_q  <= 9'd240;
      sh_r_q  <= 9'd240;
      lv_x_q  <= 10'd320;
      lv_y_q  <= 9'd240;
      lv_l_q  <= 9'd240;
      lv_r_q  <= 9'd240;
      vs1_q   <= 1'b1;
      vs2_q   <= 1'b1;
      vsp_q   <= 1'b1;
      frame_q <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      kp_q    <= 1'b0;
      ovf_q   <= 1'b0;
      sel_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sh_x_q  <= sh_x_d;
      sh_y_q  <= sh_y_d;
      sh_l_q  <= sh_l_d;
      sh_r_q  <= sh_r_d;
      lv_x_q  <= lv_x_d;
      lv_y_q  <= lv_y_d;
      lv_l_q  <= lv_l_d;
      lv_r_q  <= lv_r_d;
      vs1_q   <= vga_vs;
      vs2_q   <= vs1_q;
      vsp_q   <= vs2_q;
      frame_q <= frame_d;
      kp_q    <= ps2_key_pressed;
      ovf_q   <= ovf_d;
      sel_q   <= in_win;
      rdata_q <= rd_val;
      if (do_push) begin
        mem_q[wp_q[AW-1:0]] <= ps2_key_data;
        wp_q <= wp_q + 1'b1;
      end
      if (do_pop) rp_q <= rp_q + 1'b1;
    end
  end

  assign vga_ball_x       = lv_x_q;
  assign vga_ball_y       = lv_y_q;
  assign vga_paddle_left  = lv_l_q;
  assign vga_paddle_right = lv_r_q;

endmodule
